// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: client (I/D) and memory-side signals of the memory arbiter.
// slave modport is the arbiter's view; master modport is the environment's view.
interface mem_arbiter_if;
    logic         i_read;
    logic [15:0]  i_address;
    logic         i_resp;
    logic [127:0] i_rdata;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic         d_resp;
    logic [127:0] d_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  pmem_resp, pmem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output pmem_resp, pmem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an I-side (read only) and a
// D-side (read/write) client. A request is latched on the grant edge and the
// memory port is driven only from the latched copy until pmem_resp.
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise the D side always wins.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;

    state_t        state, next_state;
    logic [15:0]   lat_addr;
    logic [127:0]  lat_wdata;
    logic          lat_read, lat_write;
    logic          i_pend, d_pend, grant_i, grant_d;

    assign i_pend = bus.i_read;
    assign d_pend = bus.d_read | bus.d_write;

`ifdef MEM_ARBITER_RR_EN
    logic prio_d;   // 1: D side wins a tie, 0: I side wins a tie

    assign grant_d = d_pend & (~i_pend | prio_d);

    // Point at the client that did not get the transaction that just completed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_d <= 1'b1;
        else if (state == SERVE_I && bus.pmem_resp)
            prio_d <= 1'b1;
        else if (state == SERVE_D && bus.pmem_resp)
            prio_d <= 1'b0;
    end
`else
    assign grant_d = d_pend;
`endif

    assign grant_i = i_pend & ~grant_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Capture the winning request; a simultaneous read+write from D is a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                lat_addr  <= bus.d_address;
                lat_wdata <= bus.d_wdata;
                lat_write <= bus.d_write;
                lat_read  <= ~bus.d_write;
            end else if (grant_i) begin
                lat_addr  <= bus.i_address;
                lat_wdata <= '0;
                lat_write <= 1'b0;
                lat_read  <= 1'b1;
            end
        end
    end

    // Next state and all outputs; IDLE drives nothing, so stray pmem_resp is dropped
    always_comb begin
        next_state       = state;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.i_resp       = 1'b0;
        bus.i_rdata      = '0;
        bus.d_resp       = 1'b0;
        bus.d_rdata      = '0;
        case (state)
            IDLE: begin
                if (grant_d)      next_state = SERVE_D;
                else if (grant_i) next_state = SERVE_I;
            end
            SERVE_I: begin
                bus.pmem_read    = lat_read;
                bus.pmem_write   = lat_write;
                bus.pmem_address = lat_addr;
                bus.pmem_wdata   = lat_wdata;
                bus.i_resp       = bus.pmem_resp;
                bus.i_rdata      = bus.pmem_rdata;
                if (bus.pmem_resp) next_state = IDLE;
            end
            SERVE_D: begin
                bus.pmem_read    = lat_read;
                bus.pmem_write   = lat_write;
                bus.pmem_address = lat_addr;
                bus.pmem_wdata   = lat_wdata;
                bus.d_resp       = bus.pmem_resp;
                bus.d_rdata      = bus.pmem_rdata;
                if (bus.pmem_resp) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule
